// File: rtl/round_robin_arbiter_pkg.sv
// round_robin_arbiter_pkg: shared constants and one-hot decode for the round-robin arbiter
package round_robin_arbiter_pkg;
  localparam int DEFAULT_PORTS = 4;
  localparam int MAX_PORTS = 32;
  localparam int IDX_W = 5;
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) if (v[i]) idx = IDX_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/round_robin_arbiter_pick.sv
// rr_priority_pick: one-hot of the first requester at or after start, wrapping past PORTS-1
module rr_priority_pick import round_robin_arbiter_pkg::*; #(
  parameter int PORTS = DEFAULT_PORTS,
  parameter int IW = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    start,
  output logic [PORTS-1:0] pick
);
  logic found;
  logic [IW-1:0] idx;
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = IW'((int'(start) + k) % PORTS);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: sticky-grant round-robin arbiter, zero-cycle or registered grant
// ROUND_ROBIN_ARBITER_ASSERT_EN adds protocol and starvation assertions
module round_robin_arbiter import round_robin_arbiter_pkg::*; #(
  parameter int PORTS = DEFAULT_PORTS,
  parameter bit ZERO_CYCLE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [PORTS-1:0] i_req_vec,
  output logic [PORTS-1:0] o_grant_vec
);
  localparam int IW = $clog2(PORTS);
  localparam logic [IW-1:0] LAST = IW'(PORTS - 1);
  logic [PORTS-1:0] grant_q, pick, next_grant;
  logic [IW-1:0] last_q, start;
  // search begins just past the previous owner, so it ends up lowest priority
  always_comb start = (last_q == LAST) ? '0 : last_q + IW'(1);
  rr_priority_pick #(.PORTS(PORTS), .IW(IW)) u_pick (
    .req(i_req_vec),
    .start(start),
    .pick(pick)
  );
  always_comb next_grant = |(i_req_vec & grant_q) ? grant_q : pick;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      grant_q <= '0;
      last_q <= LAST;
    end else begin
      grant_q <= next_grant;
      if (|next_grant) last_q <= IW'(onehot_to_idx(MAX_PORTS'(next_grant)));
    end
  always_comb o_grant_vec = !i_rstn ? '0 : ZERO_CYCLE ? next_grant : grant_q;
`ifdef ROUND_ROBIN_ARBITER_ASSERT_EN
  logic owner_change;
  always_comb owner_change = |next_grant && next_grant != grant_q;
  a_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn) $onehot0(o_grant_vec));
  if (ZERO_CYCLE) begin : g_subset
    a_subset: assert property (@(posedge i_clk) disable iff (!i_rstn) (o_grant_vec & ~i_req_vec) == '0);
  end
  a_hold: assert property (@(posedge i_clk) disable iff (!i_rstn)
    |(grant_q & i_req_vec) |=> grant_q == $past(grant_q));
  for (genvar p = 0; p < PORTS; p++) begin : g_starve
    logic [6:0] waits;
    always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn) waits <= '0;
      else waits <= (!i_req_vec[p] || next_grant[p]) ? '0 : waits + 7'(owner_change);
    a_starve: assert property (@(posedge i_clk) disable iff (!i_rstn) waits <= 7'(PORTS));
  end
`else
`endif
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed vectors into a scoreboard, checked for both grant latencies
module tb_round_robin_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] g1, g0;
  int checks = 0;
  int passed = 0;
  int n = 0;
  typedef struct {
    int id;
    logic [3:0] e1;
    logic [3:0] e0;
  } exp_t;
  exp_t sb[$];

  round_robin_arbiter #(.PORTS(4), .ZERO_CYCLE(1'b1)) dut_zc (
    .i_clk(clk), .i_rstn(rstn), .i_req_vec(req), .o_grant_vec(g1)
  );
  round_robin_arbiter #(.PORTS(4), .ZERO_CYCLE(1'b0)) dut_reg (
    .i_clk(clk), .i_rstn(rstn), .i_req_vec(req), .o_grant_vec(g0)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] e1, input logic [3:0] e0);
    @(posedge clk);
    #1;
    rstn = r;
    req = rq;
    sb.push_back('{n, e1, e0});
    n++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (g1 === e.e1) passed++;
        else $display("FAIL step %0d zero_cycle grant: got %b want %b", e.id, g1, e.e1);
        checks++;
        if (g0 === e.e0) passed++;
        else $display("FAIL step %0d registered grant: got %b want %b", e.id, g0, e.e0);
      end
    end
  end

  initial begin : stimulus
    step(1'b0, 4'b0001, 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'b0001, 4'b0000);
    step(1'b1, 4'b0001, 4'b0001, 4'b0001);
    step(1'b1, 4'b0001, 4'b0001, 4'b0001);
    step(1'b1, 4'b0001, 4'b0001, 4'b0001);
    step(1'b1, 4'b1110, 4'b0010, 4'b0001);
    step(1'b1, 4'b1101, 4'b0100, 4'b0010);
    step(1'b1, 4'b1011, 4'b1000, 4'b0100);
    step(1'b1, 4'b0111, 4'b0001, 4'b1000);
    step(1'b1, 4'b1110, 4'b0010, 4'b0001);
    step(1'b1, 4'b0000, 4'b0000, 4'b0010);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, 4'b1111, 4'b0100, 4'b0000);
    step(1'b1, 4'b1111, 4'b0100, 4'b0100);
    step(1'b1, 4'b1111, 4'b0100, 4'b0100);
    step(1'b1, 4'b1111, 4'b0100, 4'b0100);
    step(1'b1, 4'b1010, 4'b1000, 4'b0100);
    step(1'b1, 4'b0010, 4'b0010, 4'b1000);
    step(1'b1, 4'b1000, 4'b1000, 4'b0010);
    step(1'b1, 4'b0010, 4'b0010, 4'b1000);
    step(1'b1, 4'b1000, 4'b1000, 4'b0010);
    step(1'b1, 4'b0000, 4'b0000, 4'b1000);
    step(1'b1, 4'b1000, 4'b1000, 4'b0000);
    step(1'b1, 4'b1000, 4'b1000, 4'b1000);
    step(1'b1, 4'b1001, 4'b1000, 4'b1000);
    step(1'b1, 4'b1000, 4'b1000, 4'b1000);
    step(1'b0, 4'b0100, 4'b0000, 4'b0000);
    step(1'b1, 4'b0100, 4'b0100, 4'b0000);
    step(1'b1, 4'b0100, 4'b0100, 4'b0100);
    step(1'b1, 4'b0100, 4'b0100, 4'b0100);
    step(1'b0, 4'b0100, 4'b0000, 4'b0000);
    step(1'b1, 4'b1111, 4'b0001, 4'b0000);
    step(1'b1, 4'b1111, 4'b0001, 4'b0001);
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
